// File: rtl/ram_memory_unit.sv
// Main-memory model: 2**DEPTH_LOG2 lines of DATA_W bits, combinational read port,
// synchronous write port. Reset only blocks writes; stored lines survive reset.
module ram_memory_unit #(
    parameter int    ADDR_W     = 26,
    parameter int    DATA_W     = 128,
    parameter int    DEPTH_LOG2 = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] data_requested,
    output logic [DATA_W-1:0] data_returned,
    input  logic [DATA_W-1:0] data_to_write,
    input  logic              write_to_mem,
    input  logic [ADDR_W-1:0] where_to_write
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem_q [DEPTH] = '{default: '0};
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx_d;
    logic [DATA_W-1:0]     wr_data_d;
    logic                  wr_en_d;

    // Upper address bits deliberately take no part in indexing: addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_requested[ADDR_W-1:DEPTH_LOG2],
                                where_to_write[ADDR_W-1:DEPTH_LOG2]};

    always_comb begin
        rd_idx    = data_requested[DEPTH_LOG2-1:0];
        wr_idx_d  = where_to_write[DEPTH_LOG2-1:0];
        wr_data_d = data_to_write;
        wr_en_d   = write_to_mem;
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en_d) begin
            mem_q[wr_idx_d] <= wr_data_d;
        end
    end

    // No write-data bypass: a same-index read shows the old line until the edge.
    assign data_returned = mem_q[rd_idx];

endmodule

// File: tb/tb_ram_memory_unit.sv
// Scoreboard bench for ram_memory_unit: expected lines are queued when stimulus is
// driven and popped when the combinational read is sampled.
module tb_ram_memory_unit;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] data_requested;
    logic [DATA_W-1:0] data_returned;
    logic [DATA_W-1:0] data_to_write;
    logic              write_to_mem;
    logic [ADDR_W-1:0] where_to_write;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] model [4096];
    logic [DATA_W-1:0] exp_v;

    localparam logic [DATA_W-1:0] PAT = 128'hDEADBEEF_00112233_44556677_8899AABB;

    always #5 clk = ~clk;

    ram_memory_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(12), .INIT_FILE("")
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_requested(data_requested),
        .data_returned(data_returned),
        .data_to_write(data_to_write),
        .write_to_mem(write_to_mem),
        .where_to_write(where_to_write)
    );

    function automatic logic [DATA_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One write strobe across a single rising edge; the model follows unless reset.
    task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic rst);
        @(negedge clk);
        reset          = rst;
        where_to_write = a;
        data_to_write  = d;
        write_to_mem   = 1'b1;
        @(posedge clk);
        if (!rst) model[a[11:0]] = d;
        #1;
        write_to_mem = 1'b0;
        reset        = 1'b0;
        $display("wr addr=%h data=%h reset=%0b", a, d, rst);
    endtask

    task automatic set_read(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        data_requested = a;
        #2;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        write_to_mem = 1'b0;
        repeat (2) @(posedge clk);
        set_read(26'h0000005);
        exp_q.push_back('0);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL reset_init_read: got %h expected %h", data_returned, exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        drive_write(26'h10, PAT, 1'b0);
        set_read(26'h10);
        exp_q.push_back(PAT);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL write_read: got %h expected %h", data_returned, exp_v);
        end
        set_read(26'h11);
        exp_q.push_back('0);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL neighbour_untouched: got %h expected %h", data_returned, exp_v);
        end
    endtask

    task automatic test_read_during_write();
        logic [DATA_W-1:0] line_a;
        logic [DATA_W-1:0] line_b;
        line_a = rand_line();
        line_b = ~line_a;
        drive_write(26'h20, line_a, 1'b0);
        @(negedge clk);
        data_requested = 26'h20;
        where_to_write = 26'h20;
        data_to_write  = line_b;
        write_to_mem   = 1'b1;
        exp_q.push_back(line_a);
        exp_q.push_back(line_b);
        #2;
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h (before edge)", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL rdw_before_edge: got %h expected %h", data_returned, exp_v);
        end
        @(posedge clk);
        model[12'h020] = line_b;
        #1;
        write_to_mem = 1'b0;
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h (after edge)", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL rdw_after_edge: got %h expected %h", data_returned, exp_v);
        end
    endtask

    task automatic test_reset_suppression();
        drive_write(26'h30, 128'h1, 1'b1);
        set_read(26'h30);
        exp_q.push_back('0);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL reset_blocks_write: got %h expected %h", data_returned, exp_v);
        end
        set_read(26'h10);
        exp_q.push_back(PAT);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL data_kept_over_reset: got %h expected %h", data_returned, exp_v);
        end
    endtask

    task automatic test_aliasing();
        drive_write(26'h1001, 128'hCAFE, 1'b0);
        set_read(26'h0001);
        exp_q.push_back(128'hCAFE);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL alias_low_read: got %h expected %h", data_returned, exp_v);
        end
        set_read(26'h3FFF001);
        exp_q.push_back(128'hCAFE);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL alias_high_read: got %h expected %h", data_returned, exp_v);
        end
    endtask

    task automatic test_strobe_low();
        @(negedge clk);
        where_to_write = 26'h40;
        data_to_write  = 128'hFF;
        write_to_mem   = 1'b0;
        repeat (5) @(posedge clk);
        set_read(26'h40);
        exp_q.push_back('0);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL strobe_low_no_write: got %h expected %h", data_returned, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [8];
        // Same index three times in a row: last value must win.
        drive_write(26'h50, rand_line(), 1'b0);
        drive_write(26'h50, rand_line(), 1'b0);
        drive_write(26'h50, 128'h5555_0000_AAAA_0000_5555_0000_AAAA_0000, 1'b0);
        set_read(26'h50);
        exp_q.push_back(128'h5555_0000_AAAA_0000_5555_0000_AAAA_0000);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL last_write_wins: got %h expected %h", data_returned, exp_v);
        end
        for (int i = 0; i < 8; i++) begin
            addrs[i] = ADDR_W'($urandom_range(12'h100, 12'h1FF));
            drive_write(addrs[i], rand_line(), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            set_read(addrs[i]);
            exp_q.push_back(model[addrs[i][11:0]]);
            exp_v = exp_q.pop_front();
            vectors++;
            $display("rd addr=%h data=%h", data_requested, data_returned);
            if (data_returned !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_readback[%0d]: got %h expected %h", i, data_returned, exp_v);
            end
        end
        // A write elsewhere must not disturb the line currently being read.
        set_read(26'h10);
        exp_q.push_back(PAT);
        drive_write(26'h12, rand_line(), 1'b0);
        exp_v = exp_q.pop_front();
        vectors++;
        $display("rd addr=%h data=%h", data_requested, data_returned);
        if (data_returned !== exp_v) begin
            miscompares++;
            $display("FAIL independent_ports: got %h expected %h", data_returned, exp_v);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model[i] = '0;
        reset          = 1'b1;
        write_to_mem   = 1'b0;
        data_requested = 26'h5;
        where_to_write = '0;
        data_to_write  = '0;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_reset_suppression();
        test_aliasing();
        test_strobe_low();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_memory_unit.md
# ram_memory_unit

Main-memory model behind the memory controller: a word-addressed array of 128-bit cache lines with one combinational read port and one synchronous write port. The controller drives a read line address and, for data-cache write-backs, a separate write address, write data and a one-cycle write strobe; it samples the returned line several cycles later. The RTL module is named `ram_memory_unit`.

## Interface
Parameters:
- ADDR_W, 26: width of line addresses (read and write).
- DATA_W, 128: line width in bits.
- DEPTH_LOG2, 12: log2 of stored lines (4096 lines).
- INIT_FILE, "" (empty): hex image loaded at time zero, one DATA_W line per text line; empty means all lines start at zero.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_requested  input  ADDR_W  read line address.
- data_returned  output  DATA_W  line stored at data_requested.
- data_to_write  input  DATA_W  line to store.
- write_to_mem  input  1  write strobe, one line per cycle it is high.
- where_to_write  input  ADDR_W  write line address.

## Operation
- Storage: 2^DEPTH_LOG2 lines of DATA_W bits. Index is address[DEPTH_LOG2-1:0]; upper address bits are ignored, so out-of-range addresses alias (wrap) onto the array.
- Initial contents: loaded from INIT_FILE when non-empty, otherwise all zeros. Missing lines in a short image are zero.
- Read: data_returned = array[data_requested index], combinational, no enable; never X once initialised.
- Write: at a rising clk edge with write_to_mem = 1 and reset = 0, array[where_to_write index] <= data_to_write. Full-line write, no byte enables.
- Reset: at a rising edge with reset = 1, any write is suppressed. Array contents are not cleared; the memory keeps its data across reset.
- The read and write addresses are independent; a write to one line never disturbs any other line.

## Timing
- Read latency: zero cycles (combinational from data_requested and array state).
- Write latency: value visible on data_returned immediately after the rising edge that commits it.
- Read-during-write, same index: before the edge data_returned shows the old line; after the edge it shows the new line. No bypass of data_to_write.
- Back-to-back writes: one per cycle; with consecutive writes to the same index, the last one wins.
- write_to_mem low: array unchanged regardless of where_to_write/data_to_write.
- Outputs after reset: data_returned still reflects array contents at the current address. There is no other output state.

## Test plan
- Init/read: INIT_FILE empty, data_requested = 0x0000005 -> data_returned = 0.
- Write then read: where_to_write = 0x10, data_to_write = 128'hDEADBEEF_00112233_44556677_8899AABB, write_to_mem = 1 for one edge; set data_requested = 0x10 -> that pattern. Index 0x11 still returns 0.
- Read-during-write: data_requested = where_to_write = 0x20, old line A, write line B. Before the edge data_returned = A; after the edge it = B.
- Reset suppression: reset = 1 with write_to_mem = 1 to 0x30 = 128'h1 -> line 0x30 unchanged. A line written earlier (0x10) still reads its pattern after reset deasserts.
- Aliasing: write 128'hCAFE to where_to_write = 0x1001 (DEPTH_LOG2 = 12) -> reading 0x001 returns 128'hCAFE.
- Strobe low: where_to_write = 0x40, data_to_write = 128'hFF, write_to_mem = 0 for 5 edges -> line 0x40 stays 0.
